// File: rtl/vga_ball_renderer.sv
// vga_ball_renderer
// -----------------
// Generates 640x480@60 VGA timing from a pixel-rate strobe and draws a
// BALL_SIZE x BALL_SIZE square at a ball position that is captured once per
// frame, on entry to vertical blanking, so the ball never tears mid-frame.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset (overrides pix_en)
//   pix_en      pixel strobe; all state advances only when high
//   ballX       ball top-left X (10b), sampled only at the frame latch edge
//   ballY       ball top-left Y (9b), sampled only at the frame latch edge
//   hsync       active-low horizontal sync
//   vsync       active-low vertical sync
//   video_on    high while the current pixel is inside the visible area
//   pix_x       current horizontal count
//   pix_y       current vertical count
//   rgb         RGB444 pixel colour, black outside the visible area
//   frame_start one-clk pulse on the cycle after the position latch
//
// All decoded outputs (sync, video_on, pix_x/y, rgb) are combinational from
// the counters and latched position: they change in the same clock as the
// counters, with no pipeline delay.

module vga_ball_renderer #(
  parameter int          H_VISIBLE  = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_VISIBLE  = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          BALL_SIZE  = 8,
  parameter logic [11:0] BALL_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter int          INIT_X     = 320,
  parameter int          INIT_Y     = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [9:0]  ballX,
  input  logic [8:0]  ballY,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Sized constants so every counter compare is 10-bit against 10-bit.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_LO  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_HI  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_LO  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_HI  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LATCH    = 10'(V_VISIBLE - 1);
  localparam logic [9:0] INIT_X10   = 10'(INIT_X);
  localparam logic [8:0] INIT_Y9    = 9'(INIT_Y);
  localparam logic [10:0] BALL_SZ11 = 11'(BALL_SIZE);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] lx;
  logic [8:0] ly;
  logic       latch_now;

  // The last pixel of the last visible line: leaving it enters vertical
  // blanking, which is the only moment the ball position may change.
  assign latch_now = pix_en && (h_cnt == H_LAST) && (v_cnt == V_LATCH);

  // Counters, position latch and frame_start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      lx          <= INIT_X10;
      ly          <= INIT_Y9;
      frame_start <= 1'b0;
    end else begin
      // Registered one clk after the latch edge; low on every other clk,
      // including clks without a pixel strobe.
      frame_start <= latch_now;
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          if (v_cnt == V_LAST) begin
            v_cnt <= '0;
          end else begin
            v_cnt <= v_cnt + 10'd1;
          end
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
        if (latch_now) begin
          lx <= ballX;
          ly <= ballY;
        end
      end
    end
  end

  // Timing decode.
  assign pix_x    = h_cnt;
  assign pix_y    = v_cnt;
  assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hsync    = !((h_cnt >= H_SYNC_LO) && (h_cnt <= H_SYNC_HI));
  assign vsync    = !((v_cnt >= V_SYNC_LO) && (v_cnt <= V_SYNC_HI));

  // Hit test in 11 bits so lx+BALL_SIZE / ly+BALL_SIZE cannot wrap back to
  // small values and draw a ghost ball at the left or top edge.
  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic [10:0] lx_ext;
  logic [10:0] ly_ext;
  logic        in_ball;

  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};
  assign lx_ext = {1'b0, lx};
  assign ly_ext = {2'b00, ly};

  assign in_ball = (h_ext >= lx_ext) && (h_ext < (lx_ext + BALL_SZ11)) &&
                   (v_ext >= ly_ext) && (v_ext < (ly_ext + BALL_SZ11));

  // Clipping falls out naturally: pixels of the square outside the visible
  // area are forced black by video_on.
  always_comb begin
    rgb = 12'h000;
    if (video_on) begin
      rgb = in_ball ? BALL_COLOR : BG_COLOR;
    end
  end

endmodule

// File: tb/tb_vga_ball_renderer.sv
// tb_vga_ball_renderer
// --------------------
// Two instances share one clock:
//   big   - default 640x480 timing; reset state, continuous and 1-in-4
//           strobes over several lines, reset at h=700.
//   small - shrunken timing (25x19 total, 16x12 visible) so many complete
//           frames fit the cycle budget; randomized strobes, ball positions
//           and resets, plus directed latch-edge cases.
// A reference model tracks each instance as a pixel index within the frame
// and derives expected outputs arithmetically from it.

module tb_vga_ball_renderer;

  // Small-instance geometry.
  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME_S = HT * VT;
  localparam int BS = 4, IX = 5, IY = 4;
  localparam logic [11:0] S_BALL = 12'hABC;
  localparam logic [11:0] S_BG   = 12'h123;

  // Big-instance geometry (defaults).
  localparam int FRAME_B = 800 * 525;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vid;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b, en_b, rst_s, en_s;
  logic [9:0]  bx_b, bx_s;
  logic [8:0]  by_b, by_s;
  logic        hs_b, vs_b, vid_b, fs_b;
  logic        hs_s, vs_s, vid_s, fs_s;
  logic [9:0]  x_b, y_b, x_s, y_s;
  logic [11:0] rgb_b, rgb_s;

  vga_ball_renderer u_big (
    .clk(clk), .rst(rst_b), .pix_en(en_b), .ballX(bx_b), .ballY(by_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(vid_b), .pix_x(x_b), .pix_y(y_b),
    .rgb(rgb_b), .frame_start(fs_b)
  );

  vga_ball_renderer #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BALL_SIZE(BS), .BALL_COLOR(S_BALL), .BG_COLOR(S_BG),
    .INIT_X(IX), .INIT_Y(IY)
  ) u_small (
    .clk(clk), .rst(rst_s), .pix_en(en_s), .ballX(bx_s), .ballY(by_s),
    .hsync(hs_s), .vsync(vs_s), .video_on(vid_s), .pix_x(x_s), .pix_y(y_s),
    .rgb(rgb_s), .frame_start(fs_s)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic check_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected-frame_start queue: cycle numbers at which a pulse must be seen.
  logic [31:0] exp_q_b[$];
  logic [31:0] exp_q_s[$];

  // ---------------- reference model ----------------
  int cyc = 0;
  int p_b = 0, lx_b = 320, ly_b = 240;
  int p_s = 0, lx_s = IX,  ly_s = IY;

  function automatic exp_t model_out(input int p, lx, ly, ht, vt, hv, hf, hsw,
                                     vv, vf, vsw, bs,
                                     input logic [11:0] ball, bg);
    int h, v;
    exp_t e;
    h = p % ht;
    v = (p / ht) % vt;
    e.x   = 10'(h);
    e.y   = 10'(v);
    e.vid = (h < hv) && (v < vv);
    e.hs  = !((h >= hv + hf) && (h < hv + hf + hsw));
    e.vs  = !((v >= vv + vf) && (v < vv + vf + vsw));
    if (!e.vid) e.rgb = 12'h000;
    else if (h >= lx && h < lx + bs && v >= ly && v < ly + bs) e.rgb = ball;
    else e.rgb = bg;
    return e;
  endfunction

  // Pixel index advances on each strobe; the position is captured when the
  // strobe leaves the last pixel of the last visible line.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_b) begin
      p_b <= 0; lx_b <= 320; ly_b <= 240;
    end else if (en_b) begin
      if (p_b == 480 * 800 - 1) begin
        lx_b <= int'(bx_b); ly_b <= int'(by_b);
        exp_q_b.push_back(32'(cyc + 1));
      end
      p_b <= (p_b + 1) % FRAME_B;
    end
    if (rst_s) begin
      p_s <= 0; lx_s <= IX; ly_s <= IY;
    end else if (en_s) begin
      if (p_s == VV * HT - 1) begin
        lx_s <= int'(bx_s); ly_s <= int'(by_s);
        exp_q_s.push_back(32'(cyc + 1));
      end
      p_s <= (p_s + 1) % FRAME_S;
    end
  end

  exp_t e_b, e_s;
  logic exp_fs_b, exp_fs_s;

  always @(negedge clk) begin
    if (check_on) begin
      e_b = model_out(p_b, lx_b, ly_b, 800, 525, 640, 16, 96, 480, 10, 2, 8,
                      12'hFFF, 12'h000);
      check("big_hsync", 32'(hs_b), 32'(e_b.hs));
      check("big_vsync", 32'(vs_b), 32'(e_b.vs));
      check("big_video_on", 32'(vid_b), 32'(e_b.vid));
      check("big_pix_x", 32'(x_b), 32'(e_b.x));
      check("big_pix_y", 32'(y_b), 32'(e_b.y));
      check("big_rgb", 32'(rgb_b), 32'(e_b.rgb));
      exp_fs_b = (exp_q_b.size() > 0) && (exp_q_b[0] == 32'(cyc));
      if (exp_fs_b) void'(exp_q_b.pop_front());
      check("big_frame_start", 32'(fs_b), 32'(exp_fs_b));

      e_s = model_out(p_s, lx_s, ly_s, HT, VT, HV, HF, HS, VV, VF, VS, BS,
                      S_BALL, S_BG);
      check("sm_hsync", 32'(hs_s), 32'(e_s.hs));
      check("sm_vsync", 32'(vs_s), 32'(e_s.vs));
      check("sm_video_on", 32'(vid_s), 32'(e_s.vid));
      check("sm_pix_x", 32'(x_s), 32'(e_s.x));
      check("sm_pix_y", 32'(y_s), 32'(e_s.y));
      check("sm_rgb", 32'(rgb_s), 32'(e_s.rgb));
      exp_fs_s = (exp_q_s.size() > 0) && (exp_q_s[0] == 32'(cyc));
      if (exp_fs_s) void'(exp_q_s.pop_front());
      check("sm_frame_start", 32'(fs_s), 32'(exp_fs_s));
    end
  end

  // ---------------- driver tasks ----------------
  // Strobe the small instance until the model sits on pixel index target.
  task automatic wait_small(input int target);
    int n;
    n = 0;
    en_s = 1'b1;
    while (p_s != target && n < 2 * FRAME_S) begin
      @(negedge clk);
      n++;
    end
    check("sm_wait_target", 32'(p_s == target), 32'd1);
  endtask

  task automatic run_small(input int n);
    en_s = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_ball_small();
    case ($urandom_range(0, 5))
      0: begin bx_s = 10'($urandom_range(0, HV - 1)); by_s = 9'($urandom_range(0, VV - 1)); end
      1: begin bx_s = 10'(HV - 2); by_s = 9'(VV - 2); end
      2: begin bx_s = 10'($urandom_range(0, HV - 1)); by_s = 9'(VV + $urandom_range(0, 20)); end
      3: begin bx_s = 10'($urandom_range(1020, 1023)); by_s = 9'($urandom_range(0, VV - 1)); end
      4: begin bx_s = 10'd0; by_s = 9'd0; end
      default: begin bx_s = 10'($urandom); by_s = 9'($urandom); end
    endcase
  endtask

  // ---------------- stimulus ----------------
  int n_wait;

  initial begin
    rst_b = 1'b1; rst_s = 1'b1; en_b = 1'b0; en_s = 1'b0;
    bx_b = 10'd100; by_b = 9'd50; bx_s = 10'd0; by_s = 9'd0;
    @(posedge clk);
    #1 check_on = 1'b1;
    // Reset held with pix_en high: state must not move.
    en_b = 1'b1; en_s = 1'b1;
    repeat (3) @(negedge clk);
    en_s = 1'b0;

    // Big: continuous strobes over two lines, then 1-in-4 strobes.
    rst_b = 1'b0;
    repeat (2 * 800 + 100) @(negedge clk);
    for (int i = 0; i < 4 * 900; i++) begin
      en_b = (i % 4 == 0);
      @(negedge clk);
    end

    // Big: reset at h=700 restarts at (0,0) with sync deasserted.
    en_b = 1'b1;
    n_wait = 0;
    while ((p_b % 800) != 700 && n_wait < 1000) begin
      @(negedge clk);
      n_wait++;
    end
    check("big_wait_h700", 32'((p_b % 800) == 700), 32'd1);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    repeat (900) @(negedge clk);
    en_b = 1'b0;

    // Small: directed positions, each held across a full latch.
    rst_s = 1'b0;
    bx_s = 10'd3;  by_s = 9'd2;            run_small(2 * FRAME_S);
    bx_s = 10'(HV - 2); by_s = 9'(VV - 2); run_small(2 * FRAME_S);
    bx_s = 10'd0;  by_s = 9'(VV + 1);      run_small(2 * FRAME_S);

    // Small: mid-frame change is deferred to the next frame.
    bx_s = 10'd5; by_s = 9'd3;
    wait_small(5 * HT);
    bx_s = 10'd6;
    run_small(2 * FRAME_S);

    // Small: randomized strobes, positions and occasional resets.
    for (int i = 0; i < 16000; i++) begin
      en_s = (i < 8000) ? ($urandom_range(0, 3) != 0) : (i % 4 == 0);
      if ($urandom_range(0, 39) == 0) rand_ball_small();
      rst_s = ($urandom_range(0, 2999) == 0);
      @(negedge clk);
    end
    rst_s = 1'b0;

    // Small: new position presented exactly on the latch edge is captured.
    wait_small(VV * HT - 1);
    bx_s = 10'd9; by_s = 9'd6;
    @(negedge clk);
    check("sm_fs_on_latch", 32'(fs_s), 32'd1);
    run_small(FRAME_S);

    // Small: reset coincident with the latch edge suppresses frame_start.
    wait_small(VV * HT - 1);
    rst_s = 1'b1;
    @(negedge clk);
    check("sm_fs_rst_latch", 32'(fs_s), 32'd0);
    rst_s = 1'b0;
    run_small(FRAME_S + 10);

    check_on = 1'b0;
    check("big_fs_pending", 32'(exp_q_b.size()), 32'd0);
    check("sm_fs_pending", 32'(exp_q_s.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_ball_renderer.md
Name: vga_ball_renderer

Overview:
- Downstream consumer of the ball position block.
- Generates 640x480@60 VGA timing from a pixel-rate enable.
- Latches the ball position once per frame, during vertical blanking, so the drawn ball never tears mid-frame.
- Drives 12-bit RGB: a BALL_SIZE x BALL_SIZE square at the latched position over a solid background; black outside the visible area.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch (H_TOTAL = 800)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch (V_TOTAL = 525)
BALL_SIZE, 8, ball square edge in pixels
BALL_COLOR, 12'hFFF, ball RGB444
BG_COLOR, 12'h000, background RGB444 in visible area
INIT_X, 320, latched X after reset
INIT_Y, 240, latched Y after reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pix_en  in  1  pixel strobe; counters advance only when high (e.g. 1-in-4 at 100 MHz)
ballX  in  10  ball top-left X from the ball controller; sampled only at frame latch
ballY  in  9  ball top-left Y from the ball controller; sampled only at frame latch
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
video_on  out  1  high when current pixel is inside 640x480
pix_x  out  10  current horizontal count
pix_y  out  10  current vertical count
rgb  out  12  pixel colour
frame_start  out  1  one-clk pulse, the cycle after the position latch

Behaviour:
Counters:
- h_cnt (10b) and v_cnt (10b) are registered and change only on clk edges with pix_en=1.
- h_cnt wraps from H_TOTAL-1 to 0; v_cnt increments on that wrap and wraps from V_TOTAL-1 to 0.
- With pix_en=0, all state holds.

Decode (combinational from counters, zero latency):
- pix_x = h_cnt; pix_y = v_cnt.
- video_on = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- hsync = 0 iff h_cnt in [656, 751].
- vsync = 0 iff v_cnt in [490, 491].

Position latch:
- Registers lx (10b) and ly (9b) load ballX and ballY on the clk edge where pix_en=1, h_cnt=H_TOTAL-1 and v_cnt=V_VISIBLE-1, i.e. on entry to vertical blank.
- At no other time do they load; ballX/ballY changes elsewhere are ignored.
- frame_start is registered: high for exactly one clk after the latch edge, low otherwise.

Hit test (combinational):
- Use 11-bit unsigned arithmetic so that lx+BALL_SIZE and ly+BALL_SIZE never wrap.
- in_ball = (h_cnt >= lx) && (h_cnt < lx+BALL_SIZE) && (v_cnt >= ly) && (v_cnt < ly+BALL_SIZE).
- rgb = !video_on ? 12'h000 : (in_ball ? BALL_COLOR : BG_COLOR).
- Ball partly past the right or bottom edge is clipped.
- Ball wholly outside the visible area (e.g. ly >= 480) is not drawn; no error.

Reset:
- h_cnt=0, v_cnt=0, lx=INIT_X, ly=INIT_Y, frame_start=0.
- Resulting outputs: hsync=1, vsync=1, video_on=1, pix_x=0, pix_y=0, rgb=BG_COLOR.
- Reset overrides pix_en.
- Reset mid-frame restarts at pixel (0,0) on the next clk with no partial sync pulse carried over.

Simultaneous events:
- rst and the latch condition in the same cycle: reset wins, and frame_start stays 0.
- A ballX/ballY change on the exact latch edge is captured with its new, pre-edge-sampled value.

Test Plan:
1. Reset, then pix_en=1 continuously for 800*525 cycles -> exactly 525 hsync pulses, each 96 wide starting at h=656; one vsync pulse of 2 lines starting at v=490; exactly one frame_start.
2. pix_en high every 4th clk -> all counter and sync timing scales by exactly 4; outputs held between strobes.
3. ballX=100, ballY=50 held before the latch -> next frame: rgb=BALL_COLOR exactly for h 100..107, v 50..57; BG_COLOR elsewhere in the visible area; 0 in blanking.
4. ballX changed 320->321 at v=200 mid-frame -> current frame still draws at x=320; next frame draws at x=321.
5. ballX=636, ballY=476 -> 4x4 visible corner of ball at h 636..639, v 476..479; no wrap artefacts at h=0 or v=0. Also ballY=500 -> no ball pixels drawn.
6. Assert rst at h=700, v=300 -> next clk: h=0, v=0, hsync=1, vsync=1, lx=320, ly=240, frame_start=0. Also rst coincident with the latch edge -> no frame_start pulse.
